dm_arbiter: RTL
===============

# dm_arbiter

Sequencing controller and two-way arbiter in front of the 1 KiB data memory `dm_1k`. The memory has these characteristics:

- byte-addressed, little-endian;
- 32-bit access at any byte address;
- combinational read;
- write on the rising `clk` edge while WriteEn is high.

The block shares `dm_1k` between the CPU load/store port (requester 0) and the debug/DMA port (requester 1). It runs byte and halfword stores as read-modify-write sequences, because `dm_1k` has no byte enables.

## Interface
- STARVE_MAX, default 4: consecutive CPU grants allowed while debug waits; the next arbitration goes to debug.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rq0_valid / rq1_valid  in  1  request valid.
- rq0_ready / rq1_ready  out  1  request accepted this cycle.
- rq0_we / rq1_we  in  1  1 = store, 0 = load.
- rq0_size / rq1_size  in  2  00 byte, 01 half, 10 word; 11 treated as word.
- rq0_addr / rq1_addr  in  10  byte address.
- rq0_wdata / rq1_wdata  in  32  store data, right-aligned.
- rq0_rvalid / rq1_rvalid  out  1  one-cycle load-data strobe.
- rq0_rdata / rq1_rdata  out  32  load data, zero-extended.
- dm_addr  out  10  to dm_1k addr.
- dm_din  out  32  to dm_1k din.
- dm_we  out  1  to dm_1k WriteEn.
- dm_dout  in  32  from dm_1k dout.

## Operation
- FSM states: IDLE, ACCESS, MERGE.
- **IDLE**
  - Arbitrate. rqN_ready is combinational: high only for the winner, and only while its valid is high.
  - On grant, latch id, we, size, addr and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- **Arbitration**
  - CPU has fixed priority.
  - starve_cnt (width $clog2(STARVE_MAX+1)) increments on each CPU grant made while rq1_valid is high.
  - It clears on a debug grant, or in any IDLE cycle with rq1_valid low.
  - When starve_cnt == STARVE_MAX and rq1_valid is high, debug wins.
- **ACCESS**
  - dm_addr = latched addr.
  - Load: capture dm_dout masked by size (byte [7:0], half [15:0], word all) into rdata; pulse rvalid on the next cycle; go to IDLE.
  - Word store: dm_we = 1, dm_din = wdata; go to IDLE.
  - Sub-word store: capture dm_dout into merge_q; go to MERGE.
- **MERGE**
  - dm_addr = latched addr, dm_we = 1.
  - dm_din = merge_q with the low byte (or low half) replaced by wdata; go to IDLE.
- **Response routing:** rdata and rvalid go only to the latched requester; the other requester's rdata holds its previous value.
- **Addresses:** no alignment check and no wrap logic; addr passes straight through and `dm_1k` defines the out-of-range behaviour.
- **Requester rules:** fields must be stable while valid && !ready. Dropping valid before ready is legal and leaves no side effect.
- **Requests during busy states:** a request arriving in ACCESS or MERGE waits; ready stays low.

## Timing
- Reset values: state IDLE, starve_cnt 0. All rdata, rvalid, dm_we, dm_addr and dm_din are 0. The ready outputs are combinational from IDLE and valid.
- Reset is asynchronous. Asserting rst_n mid-ACCESS or mid-MERGE drops dm_we immediately, commits no write and raises no rvalid.
- Handshake at cycle T:
  - load rdata/rvalid valid in cycle T+2;
  - word store committed at the edge ending T+1;
  - sub-word store committed at the edge ending T+2.
- Throughput: 2 cycles per load or word store, 3 per sub-word store.
- A rvalid in T+2 may coincide with the next handshake in IDLE.
- dm_we is a registered-state decode: high only in ACCESS for a word store, or in MERGE.

## Configuration
- DM_SUBWORD_EN defined: size honoured; MERGE state and merge_q present.
- DM_SUBWORD_EN undefined:
  - size is ignored and every access is word;
  - all stores complete in ACCESS;
  - MERGE and merge_q are not built.

## Structure
- Package dm_pkg holds:
  - SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10;
  - state enum dm_state_t {IDLE, ACCESS, MERGE};
  - REQ_CPU = 0, REQ_DBG = 1.
- One sub-module, dm_lane: combinational size-based extract (load masking) and merge (store insertion). It is instantiated once.

## Test plan
- Word round trip: bench preloads memory to zero. CPU stores word 0x12345678 at addr 0, then loads a word at addr 1. Required: rq0_rdata = 0x00123456 with rvalid 2 cycles after the load handshake (little-endian).
- Byte RMW: with 0x12345678 at addr 0, CPU stores byte 0xAB at addr 2. Required: dm_we is high only in the MERGE cycle, and a following word load at 0 returns 0x12AB5678.
- Half load: half load at addr 0 returns 0x00005678; byte load at addr 3 returns 0x00000012.
- Starvation: STARVE_MAX = 2, both valids held high. Required grant order: CPU, CPU, DBG, CPU, CPU, DBG.
- Reset mid-MERGE: rst_n low during MERGE of a byte store. Required: dm_we falls immediately, memory is unchanged, and state, rvalid and starve_cnt are 0.
- DM_SUBWORD_EN undefined: byte store of 0x000000AB at addr 0 writes the full word, and a load at 0 returns 0x000000AB.

Source files
------------

// File: rtl/dm_pkg.sv
// dm_pkg: size codes, requester ids and FSM states shared by dm_arbiter and dm_lane
package dm_pkg;
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_DBG = 1'b1;
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE} dm_state_t;
endpackage

// File: rtl/dm_lane.sv
// dm_lane: size-based load extraction and store insertion; code 11 behaves as a word
module dm_lane
    import dm_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [31:0] dout,
    input  logic [31:0] merge_q,
    input  logic [31:0] wdata,
    output logic [31:0] ext,
    output logic [31:0] merged
);
    assign ext    = size == SZ_BYTE ? {24'h0, dout[7:0]}
                  : size == SZ_HALF ? {16'h0, dout[15:0]} : dout;
    assign merged = size == SZ_BYTE ? {merge_q[31:8], wdata[7:0]}
                  : size == SZ_HALF ? {merge_q[31:16], wdata[15:0]} : wdata;
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-way arbiter and RMW sequencer in front of dm_1k.
// DM_SUBWORD_EN enables byte/half accesses (MERGE state, merge_q); otherwise every access is a word.
module dm_arbiter
    import dm_pkg::*;
#(
    parameter int STARVE_MAX = 4
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rq0_valid,
    output logic        rq0_ready,
    input  logic        rq0_we,
    input  logic [1:0]  rq0_size,
    input  logic [9:0]  rq0_addr,
    input  logic [31:0] rq0_wdata,
    output logic        rq0_rvalid,
    output logic [31:0] rq0_rdata,
    input  logic        rq1_valid,
    output logic        rq1_ready,
    input  logic        rq1_we,
    input  logic [1:0]  rq1_size,
    input  logic [9:0]  rq1_addr,
    input  logic [31:0] rq1_wdata,
    output logic        rq1_rvalid,
    output logic [31:0] rq1_rdata,
    output logic [9:0]  dm_addr,
    output logic [31:0] dm_din,
    output logic        dm_we,
    input  logic [31:0] dm_dout
);
    localparam int SW = $clog2(STARVE_MAX + 1);

    dm_state_t     state, state_d;
    logic [SW-1:0] starve_cnt;
    logic          id_q, we_q, sub, idle, acc, dbg_win, gnt0, gnt1, ld_done;
    logic [9:0]    addr_q;
    logic [31:0]   wdata_q, ext, merged, lane_merge;
    logic [1:0]    lane_size;

    assign idle    = state == IDLE;
    assign acc     = state == ACCESS;
    assign dbg_win = rq1_valid && (!rq0_valid || starve_cnt == SW'(STARVE_MAX));
    assign gnt1    = idle && dbg_win;
    assign gnt0    = idle && rq0_valid && !dbg_win;
    assign rq0_ready = gnt0;
    assign rq1_ready = gnt1;
    assign ld_done = acc && !we_q;

`ifdef DM_SUBWORD_EN
    logic [1:0]  size_q;
    logic [31:0] merge_q;
    assign lane_size  = size_q;
    assign lane_merge = merge_q;
    assign sub        = size_q == SZ_BYTE || size_q == SZ_HALF;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            size_q  <= SZ_WORD;
            merge_q <= '0;
        end else begin
            if (gnt0 || gnt1) size_q <= gnt1 ? rq1_size : rq0_size;
            if (acc && we_q && sub) merge_q <= dm_dout;
        end
    end
`else
    logic unused_size;
    assign unused_size = ^{rq0_size, rq1_size};
    assign lane_size   = SZ_WORD;
    assign lane_merge  = '0;
    assign sub         = 1'b0;
`endif

    dm_lane u_lane (
        .size    (lane_size),
        .dout    (dm_dout),
        .merge_q (lane_merge),
        .wdata   (wdata_q),
        .ext     (ext),
        .merged  (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Memory-side outputs decode registered state only, so reset silences them at once.
    always_comb begin
        state_d = idle ? ((gnt0 || gnt1) ? ACCESS : IDLE)
                : (acc && we_q && sub) ? MERGE : IDLE;
        dm_we   = (acc && we_q && !sub) || state == MERGE;
        dm_addr = idle ? '0 : addr_q;
        dm_din  = dm_we ? merged : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            id_q       <= REQ_CPU;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rq0_rvalid <= 1'b0;
            rq1_rvalid <= 1'b0;
            rq0_rdata  <= '0;
            rq1_rdata  <= '0;
        end else begin
            if (idle) starve_cnt <= (gnt1 || !rq1_valid) ? '0 : gnt0 ? starve_cnt + 1'b1 : starve_cnt;
            if (gnt0 || gnt1) begin
                id_q    <= gnt1;
                we_q    <= gnt1 ? rq1_we : rq0_we;
                addr_q  <= gnt1 ? rq1_addr : rq0_addr;
                wdata_q <= gnt1 ? rq1_wdata : rq0_wdata;
            end
            rq0_rvalid <= ld_done && id_q == REQ_CPU;
            rq1_rvalid <= ld_done && id_q == REQ_DBG;
            if (ld_done && id_q == REQ_CPU) rq0_rdata <= ext;
            if (ld_done && id_q == REQ_DBG) rq1_rdata <= ext;
        end
    end
endmodule
